// File: rtl/ai_wb_stream_bridge.sv
// Wishbone slave that feeds a TX FIFO out on a valid/ready stream and collects an RX stream into a FIFO.
// Optional: define AI_BRIDGE_DEBUG_EN to drive dbg_o with a registered status snapshot and TX pop counter.
module ai_wb_stream_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3200_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        irq,
    output logic [31:0] dbg_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;
    state_t state_q, state_d;

    logic          req, wr, rd, ctrl_wr, flush, stat_w1c;
    logic [5:0]    off;
    logic          en_q, ie_rx_q, ie_txe_q, ie_err_q;
    logic [2:0]    irq_stat_q, irq_stat_d, irq_set;
    logic          irq_q;
    logic [31:0]   dat_q, dat_d;

    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_wr, tx_push, tx_pop, rx_rd, rx_push, rx_pop;
    logic          unused_ok;

    assign unused_ok = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};

    assign off      = wbs_adr_i[7:2];
    assign req      = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i
                      && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr       = req && wbs_we_i;
    assign rd       = req && !wbs_we_i;
    assign ctrl_wr  = wr && (off == 6'd0) && wbs_sel_i[0];
    assign flush    = ctrl_wr && wbs_dat_i[3];
    assign stat_w1c = wr && (off == 6'd3) && wbs_sel_i[0];

    always_comb begin
        state_d   = S_IDLE;
        wbs_ack_o = 1'b0;
        if (state_q == S_IDLE) begin
            if (req) state_d = S_ACK;
        end else begin
            wbs_ack_o = 1'b1;
        end
    end

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL);

    assign m_valid = en_q && !tx_empty;
    assign m_data  = tx_mem[tx_rp_q];
    assign s_ready = en_q && !rx_full;

    // A write to a full TX is only taken when the stream frees a slot on the same edge.
    assign tx_pop  = m_valid && m_ready;
    assign tx_wr   = wr && (off == 6'd2);
    assign tx_push = tx_wr && (!tx_full || tx_pop);
    assign rx_push = s_valid && s_ready;
    assign rx_rd   = rd && (off == 6'd2);
    assign rx_pop  = rx_rd && !rx_empty;

    always_comb begin
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        irq_set  = '0;
        if (!flush) begin
            irq_set[0] = rx_push && rx_empty;
            irq_set[1] = tx_pop && (tx_cnt_d == '0);
            irq_set[2] = (tx_wr && !tx_push) || (rx_rd && rx_empty);
        end
        irq_stat_d = (irq_stat_q & ~(stat_w1c ? wbs_dat_i[2:0] : 3'b000)) | irq_set;
        if (flush) begin
            tx_cnt_d = '0;
            rx_cnt_d = '0;
        end
    end

    always_comb begin
        dat_d = dat_q;
        if (rd) begin
            case (off)
                6'd0:    dat_d = {26'd0, ie_err_q, 2'b00, ie_txe_q, ie_rx_q, en_q};
                6'd1:    dat_d = {12'd0, 4'(rx_cnt_q), 4'd0, 4'(tx_cnt_q), 4'd0,
                                  rx_empty, rx_full, tx_empty, tx_full};
                6'd2:    dat_d = rx_empty ? 32'd0 : rx_mem[rx_rp_q];
                6'd3:    dat_d = {29'd0, irq_stat_q};
                default: dat_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            dat_q      <= '0;
            en_q       <= 1'b0;
            ie_rx_q    <= 1'b0;
            ie_txe_q   <= 1'b0;
            ie_err_q   <= 1'b0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
        end else begin
            state_q    <= state_d;
            dat_q      <= dat_d;
            irq_stat_q <= irq_stat_d;
            irq_q      <= |(irq_stat_q & {ie_err_q, ie_txe_q, ie_rx_q});
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            if (ctrl_wr) begin
                en_q     <= wbs_dat_i[0];
                ie_rx_q  <= wbs_dat_i[1];
                ie_txe_q <= wbs_dat_i[2];
                ie_err_q <= wbs_dat_i[5];
            end
            if (flush) begin
                tx_wp_q <= '0;
                tx_rp_q <= '0;
                rx_wp_q <= '0;
                rx_rp_q <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
                if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
                if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
                if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (tx_push && !flush) tx_mem[tx_wp_q] <= wbs_dat_i;
        if (rx_push && !flush) rx_mem[rx_wp_q] <= s_data;
    end

    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

`ifdef AI_BRIDGE_DEBUG_EN
    logic [11:0] pop_cnt_q;
    logic [31:0] dbg_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pop_cnt_q <= '0;
            dbg_q     <= '0;
        end else begin
            if (tx_pop && !flush) pop_cnt_q <= pop_cnt_q + 12'd1;
            dbg_q <= {pop_cnt_q, irq_q, s_ready, m_valid, 1'(state_q),
                      8'(rx_cnt_q), 8'(tx_cnt_q)};
        end
    end

    assign dbg_o = dbg_q;
`else
    assign dbg_o = 32'd0;
`endif

endmodule

// File: tb/tb_ai_wb_stream_bridge.sv
// Self-checking bench for ai_wb_stream_bridge: Wishbone register access, TX/RX streams, flush and IRQs.
`timescale 1ns/1ps
module tb_ai_wb_stream_bridge;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'h3200_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DATA = BASE + 32'h8;
    localparam logic [31:0] A_IRQ  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        m_valid, m_ready, s_ready, irq;
    logic [31:0] m_data, dbg;
    logic        m_ready_drv = 1'b0, rnd_ready_en = 1'b0, rnd_bit = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] tx_seen[$];
    int          mv_cycles = 0;

    always #5 clk = ~clk;

    assign m_ready = rnd_ready_en ? rnd_bit : m_ready_drv;

    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    // Record every completed TX stream handshake just before the edge that takes it.
    always @(negedge clk) begin
        #4;
        if (m_valid) mv_cycles++;
        if (m_valid && m_ready) tx_seen.push_back(m_data);
    end

    ai_wb_stream_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .irq      (irq),
        .dbg_o    (dbg)
    );

    // One Wishbone cycle; lat is the number of clocks from strobe to ack, -1 if none within 16.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                break;
            end
        end
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        $display("wb we=%0d adr=%h wdat=%h sel=%h rdat=%h lat=%0d", w, a, d, s, r, lat);
    endtask

    task automatic rx_push(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            s_valid = 1'b1; s_data = w;
            @(negedge clk);
            s_valid = 1'b0;
        end
        $display("rx push data=%h accepted=%0d", w, ok);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int lat;
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CTRL; wdat = 32'h27; sel = 4'hF;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rdat !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", rdat); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%b exp=0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_sready got=%b exp=0", s_ready); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (dbg !== 32'h0) begin failures++; $display("FAIL reset_dbg got=%h exp=0", dbg); end
        @(negedge clk);
        wb_xfer(1'b0, A_CTRL, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL reset_lat got=%0d exp=1", lat); end
        wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_000A) begin failures++; $display("FAIL reset_status got=%h exp=0000000a", r); end
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_irqstat got=%h exp=0", r); end
    endtask

    task automatic test_single();
        logic [31:0] r, w;
        int lat, n0, mv0;
        m_ready_drv = 1'b1;
        wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, r, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL single_ctrl_lat got=%0d exp=1", lat); end
        n0 = tx_seen.size(); mv0 = mv_cycles;
        wb_xfer(1'b1, A_DATA, 32'hDEAD_BEEF, 4'hF, r, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL single_data_lat got=%0d exp=1", lat); end
        repeat (4) @(negedge clk);
        checks++; if (tx_seen.size() !== n0 + 1) begin failures++; $display("FAIL single_pops got=%0d exp=%0d", tx_seen.size(), n0 + 1); end
        w = (tx_seen.size() > n0) ? tx_seen[n0] : 32'h0;
        checks++; if (w !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_mdata got=%h exp=deadbeef", w); end
        checks++; if (mv_cycles - mv0 !== 1) begin failures++; $display("FAIL single_mvalid_cycles got=%0d exp=1", mv_cycles - mv0); end
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h2) begin failures++; $display("FAIL single_drained got=%h exp=2", r); end
        wb_xfer(1'b1, A_IRQ, 32'h7, 4'hF, r, lat);
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL single_w1c got=%h exp=0", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r, w;
        logic [31:0] words[$];
        int lat, bad, n0;
        m_ready_drv = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            w = $urandom;
            words.push_back(w);
            wb_xfer(1'b1, A_DATA, w, 4'hF, r, lat);
            if (lat != 1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL ovf_lat got=%0d exp=0", bad); end
        wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_0809) begin failures++; $display("FAIL ovf_status got=%h exp=00000809", r); end
`ifdef AI_BRIDGE_DEBUG_EN
        checks++; if (dbg[7:0] !== 8'd8) begin failures++; $display("FAIL ovf_dbg got=%h exp=08", dbg[7:0]); end
`else
        checks++; if (dbg !== 32'h0) begin failures++; $display("FAIL ovf_dbg got=%h exp=0", dbg); end
`endif
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h4) begin failures++; $display("FAIL ovf_err got=%h exp=4", r); end
        n0 = tx_seen.size();
        m_ready_drv = 1'b1;
        for (int i = 0; i < 60 && tx_seen.size() < n0 + DEPTH; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (tx_seen.size() !== n0 + DEPTH) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=%0d", tx_seen.size() - n0, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            w = (n0 + i < tx_seen.size()) ? tx_seen[n0 + i] : 32'h0;
            checks++; if (w !== words[i]) begin failures++; $display("FAIL ovf_word%0d got=%h exp=%h", i, w, words[i]); end
        end
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h6) begin failures++; $display("FAIL ovf_irqstat got=%h exp=6", r); end
        wb_xfer(1'b1, A_IRQ, 32'h7, 4'hF, r, lat);
    endtask

    task automatic test_rx();
        logic [31:0] r, w;
        logic [31:0] words[$];
        bit ok1, ok2;
        int lat, okc;
        wb_xfer(1'b1, A_CTRL, 32'h3, 4'hF, r, lat);
        rx_push(32'h11, ok1);
        rx_push(32'h22, ok2);
        checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL rx_accept got=%0d%0d exp=11", ok1, ok2); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rx_irq got=%b exp=1", irq); end
        wb_xfer(1'b0, A_DATA, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h11) begin failures++; $display("FAIL rx_read1 got=%h exp=11", r); end
        wb_xfer(1'b0, A_DATA, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h22) begin failures++; $display("FAIL rx_read2 got=%h exp=22", r); end
        wb_xfer(1'b0, A_DATA, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL rx_read_empty got=%h exp=0", r); end
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h5) begin failures++; $display("FAIL rx_irqstat got=%h exp=5", r); end
        wb_xfer(1'b1, A_IRQ, 32'h7, 4'hF, r, lat);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_clear got=%b exp=0", irq); end

        wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, r, lat);
        okc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            words.push_back(w);
            rx_push(w, ok1);
            if (ok1) okc++;
        end
        checks++; if (okc !== DEPTH) begin failures++; $display("FAIL rx_fill got=%0d exp=%0d", okc, DEPTH); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rx_full_ready got=%b exp=0", s_ready); end
        s_valid = 1'b1; s_data = $urandom;
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0008_0006) begin failures++; $display("FAIL rx_full_status got=%h exp=00080006", r); end
        for (int i = 0; i < DEPTH; i++) begin
            wb_xfer(1'b0, A_DATA, 32'h0, 4'hF, r, lat);
            checks++; if (r !== words[i]) begin failures++; $display("FAIL rx_word%0d got=%h exp=%h", i, r, words[i]); end
        end
        wb_xfer(1'b0, A_DATA, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL rx_after_drain got=%h exp=0", r); end
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h5) begin failures++; $display("FAIL rx_fill_irqstat got=%h exp=5", r); end
        wb_xfer(1'b1, A_IRQ, 32'h7, 4'hF, r, lat);
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat, n0;
        wb_xfer(1'b1, A_CTRL, 32'h0, 4'hF, r, lat);
        m_ready_drv = 1'b1;
        n0 = tx_seen.size();
        for (int i = 0; i < 3; i++) wb_xfer(1'b1, A_DATA, $urandom, 4'hF, r, lat);
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_stall_mvalid got=%b exp=0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL flush_stall_sready got=%b exp=0", s_ready); end
        wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_0308) begin failures++; $display("FAIL flush_pre_status got=%h exp=00000308", r); end
        wb_xfer(1'b1, A_CTRL, 32'h8, 4'hF, r, lat);
        wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_000A) begin failures++; $display("FAIL flush_status got=%h exp=0000000a", r); end
        wb_xfer(1'b0, A_CTRL, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL flush_ctrl got=%h exp=0", r); end
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL flush_irqstat got=%h exp=0", r); end
        wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, r, lat);
        repeat (5) @(negedge clk);
        checks++; if (tx_seen.size() !== n0) begin failures++; $display("FAIL flush_leak got=%0d exp=0", tx_seen.size() - n0); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_mvalid got=%b exp=0", m_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] r, w;
        logic [31:0] words[$];
        int lat, n0;
        m_ready_drv = 1'b0;
        n0 = tx_seen.size();
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            words.push_back(w);
            wb_xfer(1'b1, A_DATA, w, 4'hF, r, lat);
        end
        wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_0809) begin failures++; $display("FAIL fpp_pre_status got=%h exp=00000809", r); end
        w = $urandom;
        words.push_back(w);
        m_ready_drv = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_DATA; wdat = w; sel = 4'hF;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL fpp_ack got=%b exp=1", ack); end
        m_ready_drv = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        $display("wb we=1 adr=%h wdat=%h with stream pop", A_DATA, w);
        wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_0809) begin failures++; $display("FAIL fpp_status got=%h exp=00000809", r); end
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL fpp_irqstat got=%h exp=0", r); end
        m_ready_drv = 1'b1;
        for (int i = 0; i < 60 && tx_seen.size() < n0 + DEPTH + 1; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (tx_seen.size() !== n0 + DEPTH + 1) begin failures++; $display("FAIL fpp_count got=%0d exp=%0d", tx_seen.size() - n0, DEPTH + 1); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            w = (n0 + i < tx_seen.size()) ? tx_seen[n0 + i] : 32'h0;
            checks++; if (w !== words[i]) begin failures++; $display("FAIL fpp_word%0d got=%h exp=%h", i, w, words[i]); end
        end
        wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h2) begin failures++; $display("FAIL fpp_drained got=%h exp=2", r); end
        wb_xfer(1'b1, A_IRQ, 32'h7, 4'hF, r, lat);
    endtask

    task automatic test_bad_addr();
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, BASE + 32'h100, 32'h26, 4'hF, r, lat);
        checks++; if (lat !== -1) begin failures++; $display("FAIL bad_wr_ack got=%0d exp=-1", lat); end
        wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, r, lat);
        checks++; if (lat !== -1) begin failures++; $display("FAIL bad_rd_ack got=%0d exp=-1", lat); end
        wb_xfer(1'b0, A_CTRL, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h1) begin failures++; $display("FAIL bad_ctrl got=%h exp=1", r); end
        wb_xfer(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, r, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL unmapped_wr_lat got=%0d exp=1", lat); end
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%h exp=0", r); end
        wb_xfer(1'b1, A_CTRL, 32'h27, 4'hE, r, lat);
        wb_xfer(1'b0, A_CTRL, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h1) begin failures++; $display("FAIL ctrl_sel0 got=%h exp=1", r); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        $display("wb held read adr=%h ack_pattern=%b rdat=%h", A_STAT, pat, rdat);
        checks++; if (pat !== 4'b0101) begin failures++; $display("FAIL b2b_ack_pattern got=%b exp=0101", pat); end
        checks++; if (rdat !== 32'h0000_000A) begin failures++; $display("FAIL b2b_rdat got=%h exp=0000000a", rdat); end
    endtask

    task automatic test_random();
        logic [31:0] r, w;
        logic [31:0] words[$];
        int lat, k, n0;
        wb_xfer(1'b1, A_CTRL, 32'h5, 4'hF, r, lat);
        rnd_ready_en = 1'b1;
        for (int rnd = 0; rnd < 3; rnd++) begin
            words.delete();
            k = $urandom_range(1, DEPTH);
            n0 = tx_seen.size();
            for (int i = 0; i < k; i++) begin
                w = $urandom;
                words.push_back(w);
                wb_xfer(1'b1, A_DATA, w, 4'hF, r, lat);
            end
            for (int i = 0; i < 200 && tx_seen.size() < n0 + k; i++) @(negedge clk);
            repeat (3) @(negedge clk);
            checks++; if (tx_seen.size() !== n0 + k) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", rnd, tx_seen.size() - n0, k); end
            for (int i = 0; i < k; i++) begin
                w = (n0 + i < tx_seen.size()) ? tx_seen[n0 + i] : 32'h0;
                checks++; if (w !== words[i]) begin failures++; $display("FAIL rnd%0d_word%0d got=%h exp=%h", rnd, i, w, words[i]); end
            end
            checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rnd%0d_irq got=%b exp=1", rnd, irq); end
            wb_xfer(1'b0, A_IRQ, 32'h0, 4'hF, r, lat);
            checks++; if (r !== 32'h2) begin failures++; $display("FAIL rnd%0d_irqstat got=%h exp=2", rnd, r); end
            wb_xfer(1'b1, A_IRQ, 32'h7, 4'hF, r, lat);
            @(negedge clk);
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rnd%0d_irq_clear got=%b exp=0", rnd, irq); end
        end
        rnd_ready_en = 1'b0;
        m_ready_drv = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_rx();
        test_flush();
        test_full_push_pop();
        test_bad_addr();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
